// File: rtl/axichacha_pkg.sv
// Shared constants for the AXI-Stream to ChaCha block path.
package axichacha_pkg;

    localparam int CHACHA_BLOCK_WORDS = 16;
    localparam int CHACHA_WORD_W      = 32;
    localparam int CHACHA_BLOCK_W     = CHACHA_WORD_W * CHACHA_BLOCK_WORDS;

    // Assembly buffer state: FILL collects words, DONE waits for the output register.
    typedef enum logic {
        ASM_FILL = 1'b0,
        ASM_DONE = 1'b1
    } asm_state_t;

endpackage

// File: rtl/axis_block_packer.sv
// Packs a stream of WORD_W words into BLOCK_WORDS-word blocks.
// A tlast word closes the block early and the unfilled slots read as zero.
//
// Handshakes:
//   Input:  a word transfers on a rising edge where s00_axis_tvalid && s00_axis_tready.
//   Output: a block transfers on a rising edge where m00_blk_valid && m00_blk_ready.
//           While m00_blk_valid && !m00_blk_ready, every m00_blk_* output holds.
//
// The assembly buffer and the output register form a two-deep pipeline.
// A finished block moves into the output register whenever that register is
// empty or being drained, so one word per cycle is sustained while the consumer
// accepts every cycle.
module axis_block_packer
    import axichacha_pkg::*;
#(
    parameter  int WORD_W      = CHACHA_WORD_W,
    parameter  int BLOCK_WORDS = CHACHA_BLOCK_WORDS,
    localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1,
    localparam int BLK_W       = WORD_W * BLOCK_WORDS
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_aresetn,
    input  logic [WORD_W-1:0] s00_axis_tdata,
    input  logic              s00_axis_tvalid,
    input  logic              s00_axis_tlast,
    output logic              s00_axis_tready,
    output logic [BLK_W-1:0]  m00_blk_data,
    output logic [CNT_W-1:0]  m00_blk_words,
    output logic              m00_blk_last,
    output logic              m00_blk_valid,
    input  logic              m00_blk_ready
);

    asm_state_t         r_state;
    asm_state_t         w_state_nxt;
    logic [BLK_W-1:0]   r_asm_data;
    logic [BLK_W-1:0]   w_asm_data_nxt;
    logic [CNT_W-1:0]   r_asm_cnt;
    logic [CNT_W-1:0]   w_asm_cnt_nxt;
    logic               r_asm_last;
    logic               w_asm_last_nxt;

    logic [BLK_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_words;
    logic               r_out_last;
    logic               r_out_valid;

    logic               w_out_free;
    logic               w_move;
    logic               w_accept;
    logic [CNT_W-1:0]   w_slot;
    logic [BLK_W-1:0]   w_masked;

    // The output register can take a block when it is empty or being drained now.
    assign w_out_free = !r_out_valid || m00_blk_ready;
    assign w_move     = (r_state == ASM_DONE) && w_out_free;

    // Held low during reset; in DONE the input only proceeds when the block moves out.
    assign s00_axis_tready = s00_axis_aresetn && ((r_state == ASM_FILL) || w_out_free);
    assign w_accept        = s00_axis_tvalid && s00_axis_tready;

    // A word accepted alongside a move starts the fresh buffer at slot 0.
    assign w_slot = w_move ? '0 : r_asm_cnt;

    // Assembly next state: clear on move, then write the accepted word.
    always_comb begin
        w_state_nxt    = r_state;
        w_asm_data_nxt = r_asm_data;
        w_asm_cnt_nxt  = r_asm_cnt;
        w_asm_last_nxt = r_asm_last;
        if (w_move) begin
            w_state_nxt    = ASM_FILL;
            w_asm_cnt_nxt  = '0;
            w_asm_last_nxt = 1'b0;
        end
        if (w_accept) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                if (w_slot == CNT_W'(k)) begin
                    w_asm_data_nxt[k*WORD_W +: WORD_W] = s00_axis_tdata;
                end
            end
            w_asm_cnt_nxt  = w_slot + CNT_W'(1);
            w_asm_last_nxt = s00_axis_tlast;
            if (s00_axis_tlast || (w_slot == CNT_W'(BLOCK_WORDS - 1))) begin
                w_state_nxt = ASM_DONE;
            end
        end
    end

    // Slots at or beyond the fill count are zeroed so stale words never leave.
    always_comb begin
        w_masked = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (CNT_W'(k) < r_asm_cnt) begin
                w_masked[k*WORD_W +: WORD_W] = r_asm_data[k*WORD_W +: WORD_W];
            end
        end
    end

    // Assembly buffer registers.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state    <= ASM_FILL;
            r_asm_data <= '0;
            r_asm_cnt  <= '0;
            r_asm_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_asm_data <= w_asm_data_nxt;
            r_asm_cnt  <= w_asm_cnt_nxt;
            r_asm_last <= w_asm_last_nxt;
        end
    end

    // Output register: load on move, otherwise drop valid once the block is taken.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_out_data  <= '0;
            r_out_words <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_move) begin
            r_out_data  <= w_masked;
            r_out_words <= r_asm_cnt;
            r_out_last  <= r_asm_last;
            r_out_valid <= 1'b1;
        end else if (m00_blk_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign m00_blk_data  = r_out_data;
    assign m00_blk_words = r_out_words;
    assign m00_blk_last  = r_out_last;
    assign m00_blk_valid = r_out_valid;

endmodule

// File: tb/tb_axis_block_packer.sv
// Bench for axis_block_packer: directed phases plus a randomized phase, with
// expected blocks built from the accepted word stream by a queue-based model.
module tb_axis_block_packer;
    import axichacha_pkg::*;

    localparam int W   = 32;
    localparam int BW  = 16;
    localparam int CW  = 5;
    localparam int BLK = W * BW;
    localparam int EW  = BLK + CW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           aresetn;
    logic [W-1:0]   tdata;
    logic           tvalid;
    logic           tlast;
    logic           tready;
    logic [BLK-1:0] bdata;
    logic [CW-1:0]  bwords;
    logic           blast;
    logic           bvalid;
    logic           bready;

    axis_block_packer #(.WORD_W(W), .BLOCK_WORDS(BW)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (aresetn),
        .s00_axis_tdata   (tdata),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tlast   (tlast),
        .s00_axis_tready  (tready),
        .m00_blk_data     (bdata),
        .m00_blk_words    (bwords),
        .m00_blk_last     (blast),
        .m00_blk_valid    (bvalid),
        .m00_blk_ready    (bready)
    );

    // ---------------- scoreboard ----------------
    int n_total;
    int n_pass;
    logic [EW-1:0] exp_q[$];   // {last, words, data} per expected block
    logic [W-1:0]  cur_q[$];   // words of the block being assembled
    logic          smp_valid;
    logic          smp_acc;
    logic          smp_tready;
    logic          prev_stall;
    logic [EW-1:0] prev_out;

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // A block closes after BW words or on a tlast word; missing slots are zero.
    task automatic model_accept(input logic [W-1:0] d, input logic l);
        logic [BLK-1:0] blk;
        cur_q.push_back(d);
        if (cur_q.size() == BW || l) begin
            blk = '0;
            foreach (cur_q[k]) blk[k*W +: W] = cur_q[k];
            exp_q.push_back({l, CW'(cur_q.size()), blk});
            cur_q.delete();
        end
    endtask

    // ---------------- driver ----------------
    // Drive at the falling edge, sample 1 time unit before the rising edge.
    task automatic tick(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        logic [EW-1:0] got;
        @(negedge clk);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        bready = r;
        #4;
        got        = {blast, bwords, bdata};
        smp_valid  = bvalid;
        smp_tready = tready;
        smp_acc    = tvalid && tready;
        if (prev_stall) check("hold_stable", got, prev_out);
        if (bvalid && bready) begin
            if (exp_q.size() == 0) check("no_block_expected", EW'(bvalid), '0);
            else check("block", got, exp_q.pop_front());
        end
        prev_stall = bvalid && !bready;
        prev_out   = got;
        if (smp_acc) model_accept(d, l);
        @(posedge clk);
    endtask

    // Send n words from base; tlast on the final one if fin_last; rnd_ready randomizes ready.
    task automatic send_msg(input logic [W-1:0] base, input int n, input logic fin_last,
                            input logic rnd_ready);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 20 * n + 50) begin
            tick(1'b1, base + W'(idx), fin_last && (idx == n - 1),
                 rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (smp_acc) idx++;
            budget++;
        end
        check("send_done", EW'(idx), EW'(n));
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || bvalid) && n < max_cycles) begin
            tick(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        check("drain_empty", EW'(exp_q.size()), '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int w;
        int idx;
        int budget;
        n_total    = 0;
        n_pass     = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        tvalid     = 1'b0;
        tdata      = '0;
        tlast      = 1'b0;
        bready     = 1'b0;
        aresetn    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_tready",  EW'(tready), '0);
        check("rst_valid",   EW'(bvalid), '0);
        check("rst_data",    EW'(bdata),  '0);
        check("rst_words",   EW'(bwords), '0);
        check("rst_last",    EW'(blast),  '0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("post_rst_tready", EW'(tready), EW'(1));

        // Contiguous stream: 32 words at full rate, ready always high
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, W'(i), 1'b0, 1'b1);
            if (smp_acc) acc++;
        end
        check("contig_accepts", EW'(acc), EW'(32));
        drain(40);

        // Alternating valid, then block latency after the 16th accept
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, W'(i), 1'b0, 1'b1);
            tick(1'b0, '0, 1'b0, 1'b1);
        end
        tick(1'b1, W'(15), 1'b0, 1'b1);
        check("alt_last_accept", EW'(smp_acc), EW'(1));
        tick(1'b0, '0, 1'b0, 1'b1);
        check("lat_not_early", EW'(smp_valid), '0);
        tick(1'b0, '0, 1'b0, 1'b1);
        check("lat_valid", EW'(smp_valid), EW'(1));
        drain(10);

        // Partial block closed by tlast on word 5, then a short next message
        send_msg(32'h0, 6, 1'b1, 1'b0);
        send_msg(32'hA0, 3, 1'b1, 1'b0);
        drain(20);

        // Backpressure: consumer stalled for 40 cycles
        w = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 32'h200 + W'(w), 1'b0, 1'b0);
            if (smp_acc) w++;
        end
        check("bp_accepts", EW'(w), EW'(32));
        check("bp_tready_low", EW'(smp_tready), '0);
        tick(1'b1, 32'h200 + W'(w), 1'b0, 1'b1);
        check("bp_resume", EW'(smp_tready), EW'(1));
        if (smp_acc) w++;
        budget = 0;
        while (w < 48 && budget < 100) begin
            tick(1'b1, 32'h200 + W'(w), 1'b0, 1'b1);
            if (smp_acc) w++;
            budget++;
        end
        check("bp_total", EW'(w), EW'(48));
        drain(40);

        // tlast on the 16th word, next message starting in the move cycle
        send_msg(32'h300, 16, 1'b1, 1'b0);
        send_msg(32'h400, 4, 1'b1, 1'b0);
        drain(20);

        // Randomized traffic: gaps, random tlast, random consumer ready
        idx = 0;
        budget = 0;
        while (idx < 150 && budget < 3000) begin
            tick($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0);
            if (smp_acc) idx++;
            budget++;
        end
        check("rand_words", EW'(idx), EW'(150));
        // Close any partial block so the model and the DUT both finish it.
        send_msg(32'hBEEF0000, 1, 1'b1, 1'b0);
        drain(60);

        // Reset mid-block: 7 words, asynchronous reset between edges
        for (int i = 0; i < 7; i++) tick(1'b1, 32'h500 + W'(i), 1'b0, 1'b1);
        @(negedge clk);
        tvalid  = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid",  EW'(bvalid), '0);
        check("mid_rst_data",   EW'(bdata),  '0);
        check("mid_rst_words",  EW'(bwords), '0);
        check("mid_rst_tready", EW'(tready), '0);
        exp_q.delete();
        cur_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        send_msg(32'h100, 16, 1'b0, 1'b0);
        drain(20);
        check("model_residue", EW'(cur_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
